// File: rtl/sample_iterator.sv
// Walks a latched bounding box on the sample grid in raster order (x fastest), one sample per clock.
// Latency: first sample one cycle after acceptance; halt is held while further samples remain.
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R15S,
    input  logic        [COLORS-1:0][SIGFIG-1:0]      color_R15U,
    input  logic signed [1:0][1:0][SIGFIG-1:0]        box_R15S,
    input  logic                                      validTri_R15H,
    input  logic        [3:0]                         subSample_RnnnnU,
    output logic                                      halt_RnnnnH,
    output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
    output logic        [COLORS-1:0][SIGFIG-1:0]      color_R16U,
    output logic signed [1:0][SIGFIG-1:0]             sample_R16S,
    output logic                                      validSamp_R16H
);

    typedef enum logic {WAIT = 1'b0, TEST = 1'b1} state_t;
    localparam int W = SIGFIG + 1;
    localparam logic [SIGFIG-1:0] ONE = SIGFIG'(1);

    state_t state, state_nx;

    logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
    logic [COLORS-1:0][SIGFIG-1:0] color_q;
    logic [SIGFIG-1:0] ll_x_q, ur_x_q, ur_y_q, step_q;
    logic [SIGFIG-1:0] x_q, y_q;
    logic              vld_q;

    logic [SIGFIG-1:0] in_ll_x, in_ll_y, in_ur_x, in_ur_y, in_step;
    logic [SIGFIG-1:0] cur_ll_x, cur_ur_x, cur_ur_y, cur_step;
    logic [SIGFIG-1:0] nx, ny;
    logic signed [W-1:0] sstep, x_try, y_try;
    logic in_legal, accept, done;

    // Sign-extend by one bit so step additions near the signed maximum cannot wrap.
    function automatic logic signed [W-1:0] sext(input logic [SIGFIG-1:0] v);
        return $signed({v[SIGFIG-1], v});
    endfunction

    assign in_ll_x = box_R15S[0][0];
    assign in_ll_y = box_R15S[0][1];
    assign in_ur_x = box_R15S[1][0];
    assign in_ur_y = box_R15S[1][1];

    always_comb begin
        case (subSample_RnnnnU)
            4'b0100: in_step = ONE << (RADIX - 1);
            4'b0010: in_step = ONE << (RADIX - 2);
            4'b0001: in_step = ONE << (RADIX - 3);
            default: in_step = ONE << RADIX;
        endcase
    end

    assign in_legal = (sext(in_ur_x) >= sext(in_ll_x)) && (sext(in_ur_y) >= sext(in_ll_y));
    assign accept   = (state == WAIT) && validTri_R15H && in_legal;

    assign cur_ll_x = (state == TEST) ? ll_x_q : in_ll_x;
    assign cur_ur_x = (state == TEST) ? ur_x_q : in_ur_x;
    assign cur_ur_y = (state == TEST) ? ur_y_q : in_ur_y;
    assign cur_step = (state == TEST) ? step_q : in_step;
    assign sstep    = $signed({1'b0, cur_step});
    assign x_try    = sext(x_q) + sstep;
    assign y_try    = sext(y_q) + sstep;

    always_comb begin
        nx = in_ll_x;
        ny = in_ll_y;
        if (state == TEST) begin
            if (x_try <= sext(cur_ur_x)) begin
                nx = x_try[SIGFIG-1:0];
                ny = y_q;
            end else begin
                nx = cur_ll_x;
                ny = y_try[SIGFIG-1:0];
            end
        end
    end

    // The sample about to be emitted is the last one when neither axis can step further.
    assign done = ((sext(nx) + sstep) > sext(cur_ur_x)) && ((sext(ny) + sstep) > sext(cur_ur_y));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= WAIT;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            WAIT:    if (accept && !done) state_nx = TEST;
            TEST:    if (done) state_nx = WAIT;
            default: state_nx = WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tri_q   <= '0;
            color_q <= '0;
            ll_x_q  <= '0;
            ur_x_q  <= '0;
            ur_y_q  <= '0;
            step_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            vld_q   <= 1'b0;
        end else begin
            vld_q <= accept || (state == TEST);
            if (accept) begin
                tri_q   <= tri_R15S;
                color_q <= color_R15U;
                ll_x_q  <= in_ll_x;
                ur_x_q  <= in_ur_x;
                ur_y_q  <= in_ur_y;
                step_q  <= in_step;
            end
            if (accept || state == TEST) begin
                x_q <= nx;
                y_q <= ny;
            end
        end
    end

    always_comb begin
        halt_RnnnnH    = (state == TEST);
        validSamp_R16H = vld_q;
        sample_R16S    = {y_q, x_q};
        tri_R16S       = tri_q;
        color_R16U     = color_q;
    end

endmodule

// File: doc/sample_iterator.md
SAMPLE_ITERATOR -- requirements
Module: sample_iterator

Interface
REQ-001 SHALL have parameter: SIGFIG, 24, bits in position/color words.
REQ-002 SHALL have parameter: RADIX, 10, fraction bits; 1.0 = 1<<RADIX.
REQ-003 SHALL have parameter: VERTS, 3, vertices per triangle.
REQ-004 SHALL have parameter: AXIS, 3, axes per vertex (x,y,z).
REQ-005 SHALL have parameter: COLORS, 3, color channels.
REQ-006 SHALL have port: clk  input  1  clock; single clock domain, all state on rising edge.
REQ-007 SHALL have port: rst  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port: tri_R15S  input  [VERTS][AXIS]xSIGFIG signed  triangle vertices.
REQ-009 SHALL have port: color_R15U  input  [COLORS]xSIGFIG unsigned  triangle color.
REQ-010 SHALL have port: box_R15S  input  [2][2]xSIGFIG signed  bounding box; [0]=lower-left, [1]=upper-right; [.][0]=x, [.][1]=y; snapped to the sample grid.
REQ-011 SHALL have port: validTri_R15H  input  1  triangle and box valid.
REQ-012 SHALL have port: subSample_RnnnnU  input  4  one-hot sample rate: 1000=1/pixel, 0100=4, 0010=16, 0001=64.
REQ-013 SHALL have port: halt_RnnnnH  output  1  iterator busy; upstream holds its inputs.
REQ-014 SHALL have port: tri_R16S, color_R16U  output  same shapes as inputs  latched triangle and color.
REQ-015 SHALL have port: sample_R16S  output  [2]xSIGFIG signed  sample (x,y).
REQ-016 SHALL have port: validSamp_R16H  output  1  sample_R16S valid this cycle.

Function
REQ-017 SHALL step size: 1000 -> 1<<RADIX; 0100 -> 1<<(RADIX-1); 0010 -> 1<<(RADIX-2); 0001 -> 1<<(RADIX-3); any non-one-hot value -> 1<<RADIX.
REQ-018 SHALL implement a two-state FSM, WAIT and TEST; halt_RnnnnH = (state==TEST), registered.
REQ-019 SHALL, in WAIT with validTri_R15H=1 and a legal box, at the next edge: latch tri, color, box and step; drive sample_R16S = box lower-left; set validSamp_R16H=1; go to TEST unless the box is a single sample.
REQ-020 SHALL, in WAIT with validTri_R15H=0, drive validSamp_R16H=0 and leave the other outputs at their last values.
REQ-021 SHALL treat a box with ur_x<ll_x or ur_y<ll_y as illegal: no samples, stay in WAIT, halt stays 0.
REQ-022 SHALL, in TEST, emit one sample per cycle in raster order, x fastest: if x+step <= ur_x then x+=step; else x=ll_x and y+=step.
REQ-023 SHALL compute x+step and y+step in SIGFIG+1 bits so no comparison wraps near the signed maximum.
REQ-024 SHALL return to WAIT on the edge that emits sample (ur_x', ur_y'), the last grid point <= ur; halt falls on that same edge.
REQ-025 SHALL ignore validTri_R15H and all R15 inputs while in TEST.
REQ-026 SHALL emit exactly ((ur_x-ll_x)/step+1)*((ur_y-ll_y)/step+1) samples per legal triangle.
REQ-027 SHALL give one-cycle latency from accepted triangle to first sample.
REQ-028 SHALL allow back-to-back operation: a validTri in the cycle after WAIT is re-entered is accepted with no bubble beyond that cycle.

Reset
REQ-029 SHALL, while rst=0, immediately force state=WAIT, halt_RnnnnH=0, validSamp_R16H=0, and sample_R16S, tri_R16S, color_R16U=0, regardless of the clock.
REQ-030 SHALL abandon an in-progress triangle when reset is asserted mid-iteration; no sample of it appears after release.
REQ-031 SHALL accept a new triangle on the first rising edge after rst returns to 1.

Verification
REQ-032 SHALL test 1x box: box ll=(0,0), ur=(2048,1024), subSample=1000 -> samples (0,0),(1024,0),(2048,0),(0,1024),(1024,1024),(2048,1024) on 6 consecutive cycles; halt=1 for exactly 5 cycles.
REQ-033 SHALL test a single-sample box: ll=ur=(512,512) -> one sample (512,512), validSamp=1 for 1 cycle, halt never asserted.
REQ-034 SHALL test 4x rate: ll=(0,0), ur=(1024,0), subSample=0100 -> samples x=0,512,1024 at y=0; subSample=0110 behaves as 1x -> x=0,1024.
REQ-035 SHALL test an illegal box: ll=(2048,0), ur=(1024,0) -> no validSamp, halt stays 0; next legal triangle is accepted normally.
REQ-036 SHALL test reset mid-run: assert rst=0 after the 3rd sample of the REQ-032 case -> outputs go to zero asynchronously; after release, no further samples until a new validTri.
REQ-037 SHALL test input changes under halt: change tri/color/box during TEST -> emitted samples and tri_R16S/color_R16U keep the latched values.
